// File: rtl/xfer_cycle_sched.sv
`default_nettype none
// ============================================================================
//  Module   : xfer_cycle_sched
//  Purpose  : Per-control-cycle transfer scheduler. On an accepted
//             cycle_tick it walks the enabled phases (in -> xnet -> out),
//             issuing a one-clock enable per phase, waiting for the mover's
//             move_done, inserting PHASE_GAP idle clocks between phases and
//             finishing with a one-clock cycle_done pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYC : max clocks to wait for move_done in one phase (watchdog)
//    PHASE_GAP   : idle clocks between one phase's done and the next REQ
//  Ports
//    sys_clk_50m  in   1  clock
//    sys_rst      in   1  asynchronous active-high reset
//    init_ok      in   1  configuration valid; low aborts/blocks cycles
//    cycle_tick   in   1  control-cycle start pulse
//    phase_mask   in   3  phase enables {out, xnet, in}, latched at accept
//    move_done    in   1  mover finished current phase (honoured in WAIT only)
//    err_clr      in   1  clears sched_err and ovr_cnt
//    xfer_in_en   out  1  input-transfer start pulse
//    xnet_en      out  1  network-transfer start pulse
//    xfer_out_en  out  1  output-transfer start pulse
//    sched_busy   out  1  cycle in progress
//    sched_phase  out  2  0 none, 1 in, 2 xnet, 3 out
//    sched_err    out  1  sticky watchdog timeout flag
//    ovr_cnt      out  8  saturating count of dropped cycle_tick pulses
//    cycle_done   out  1  cycle completion pulse
//  Build option
//    XFER_SCHED_WDT_EN : enables the WAIT-state watchdog and sched_err.
//                        Undefined: WAIT waits forever, sched_err = 0.
// ============================================================================
module xfer_cycle_sched #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [3:0]  PHASE_GAP   = 4'd2
) (
  input  logic       sys_clk_50m,
  input  logic       sys_rst,
  input  logic       init_ok,
  input  logic       cycle_tick,
  input  logic [2:0] phase_mask,
  input  logic       move_done,
  input  logic       err_clr,
  output logic       xfer_in_en,
  output logic       xnet_en,
  output logic       xfer_out_en,
  output logic       sched_busy,
  output logic [1:0] sched_phase,
  output logic       sched_err,
  output logic [7:0] ovr_cnt,
  output logic       cycle_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] mask_q,  mask_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] gap_q,   gap_d;
  logic [2:0] en_q,    en_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic [7:0] ovr_q,   ovr_d;
  logic [2:0] w_rest;
  logic [1:0] w_next;
  logic       w_timeout;

  // Lowest-numbered enabled phase (1..3), 0 when none is enabled.
  function automatic logic [1:0] first_phase(input logic [2:0] m);
    if (m[0])      first_phase = 2'd1;
    else if (m[1]) first_phase = 2'd2;
    else if (m[2]) first_phase = 2'd3;
    else           first_phase = 2'd0;
  endfunction

  // Enabled phases strictly after the current one.
  always_comb begin
    w_rest = 3'b000;
    case (phase_q)
      2'd1:    w_rest = mask_q & 3'b110;
      2'd2:    w_rest = mask_q & 3'b100;
      default: w_rest = 3'b000;
    endcase
  end

  assign w_next = first_phase(w_rest);

`ifdef XFER_SCHED_WDT_EN
  logic [15:0] wdt_q;
  logic        err_q;

  // Held at zero outside WAIT, so it restarts from 0 on every WAIT entry.
  always_ff @(posedge sys_clk_50m or posedge sys_rst) begin
    if (sys_rst)                wdt_q <= 16'd0;
    else if (state_q == S_WAIT) wdt_q <= wdt_q + 16'd1;
    else                        wdt_q <= 16'd0;
  end

  // A move_done in the timeout clock completes the phase normally.
  assign w_timeout = (state_q == S_WAIT) && (wdt_q == TIMEOUT_CYC) &&
                     !move_done && init_ok;

  always_ff @(posedge sys_clk_50m or posedge sys_rst) begin
    if (sys_rst)        err_q <= 1'b0;
    else if (err_clr)   err_q <= 1'b0;
    else if (w_timeout) err_q <= 1'b1;
  end

  assign sched_err = err_q;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYC;
  assign w_timeout    = 1'b0;
  assign sched_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    en_d    = 3'b000;
    done_d  = 1'b0;

    if ((state_q != S_IDLE) && !init_ok) begin
      // Configuration lost mid-cycle: drop everything silently.
      state_d = S_IDLE;
      busy_d  = 1'b0;
      phase_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cycle_tick && init_ok) begin
            mask_d  = phase_mask;
            busy_d  = 1'b1;
            phase_d = first_phase(phase_mask);
            state_d = (phase_mask == 3'b000) ? S_FIN : S_REQ;
          end
        end
        S_REQ: begin
          case (phase_q)
            2'd1:    en_d = 3'b001;
            2'd2:    en_d = 3'b010;
            2'd3:    en_d = 3'b100;
            default: en_d = 3'b000;
          endcase
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (move_done) begin
            if (w_next != 2'd0) begin
              phase_d = w_next;
              gap_d   = 4'd0;
              state_d = (PHASE_GAP == 4'd0) ? S_REQ : S_GAP;
            end else begin
              state_d = S_FIN;
            end
          end else if (w_timeout) begin
            state_d = S_FIN;
          end
        end
        S_GAP: begin
          if (gap_q == PHASE_GAP - 4'd1) state_d = S_REQ;
          else                           gap_d   = gap_q + 4'd1;
        end
        S_FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          phase_d = 2'd0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Dropped ticks: busy or unconfigured. Clear has priority.
    ovr_d = ovr_q;
    if (err_clr)
      ovr_d = 8'd0;
    else if (cycle_tick && (busy_q || !init_ok) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge sys_clk_50m or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      mask_q  <= 3'b000;
      phase_q <= 2'd0;
      gap_q   <= 4'd0;
      en_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign xfer_in_en  = en_q[0];
  assign xnet_en     = en_q[1];
  assign xfer_out_en = en_q[2];
  assign sched_busy  = busy_q;
  assign sched_phase = phase_q;
  assign ovr_cnt     = ovr_q;
  assign cycle_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_xfer_cycle_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xfer_cycle_sched
//  Purpose  : Self-checking bench for xfer_cycle_sched: reset state, a table
//             of single cycles per phase mask, hand-written corner sequences
//             (overrun, init_ok abort, reset mid-phase, watchdog when built
//             with XFER_SCHED_WDT_EN) and a random run against an
//             event-time reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xfer_cycle_sched;

  localparam int GAP = 2;

  logic       sys_clk_50m = 1'b0;
  logic       sys_rst, init_ok, cycle_tick, move_done, err_clr;
  logic [2:0] phase_mask;
  logic       xfer_in_en, xnet_en, xfer_out_en, sched_busy, sched_err, cycle_done;
  logic [1:0] sched_phase;
  logic [7:0] ovr_cnt;
  logic [2:0] en_w;

  xfer_cycle_sched #(.TIMEOUT_CYC(16'd100), .PHASE_GAP(4'd2)) dut (
    .sys_clk_50m (sys_clk_50m),
    .sys_rst     (sys_rst),
    .init_ok     (init_ok),
    .cycle_tick  (cycle_tick),
    .phase_mask  (phase_mask),
    .move_done   (move_done),
    .err_clr     (err_clr),
    .xfer_in_en  (xfer_in_en),
    .xnet_en     (xnet_en),
    .xfer_out_en (xfer_out_en),
    .sched_busy  (sched_busy),
    .sched_phase (sched_phase),
    .sched_err   (sched_err),
    .ovr_cnt     (ovr_cnt),
    .cycle_done  (cycle_done)
  );

  always #10 sys_clk_50m = ~sys_clk_50m;
  assign en_w = {xfer_out_en, xnet_en, xfer_in_en};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // All sampling and driving happens 1 ns after the rising edge.
  task automatic step();
    @(posedge sys_clk_50m);
    #1;
  endtask

  // Step until enable bit idx is high (checked at the current sample first).
  task automatic wait_en(input int idx, input string name);
    int seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (en_w[idx]) begin seen = 1; break; end
      step();
    end
    check(name, seen, 1);
  endtask

  // One full cycle: tick with mask m, mover answers dly clocks after each enable.
  // Cycle numbers count samples after the clock on which the tick was driven.
  task automatic run_vec(input logic [2:0] m, input int dly,
                         output logic [2:0] seen, output logic [2:0] first_bits,
                         output int first, output int last, output int lat,
                         output bit ph2, output int dones, output int extra);
    int done_at;
    seen = 3'b000; first_bits = 3'b000; first = -1; last = -1; lat = -1;
    ph2 = 1'b0; dones = 0; extra = 0; done_at = -1;
    phase_mask = m; cycle_tick = 1'b1; move_done = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      step();
      cycle_tick = 1'b0;
      phase_mask = 3'($urandom);   // must have been latched already
      if (en_w != 3'b000) begin
        if ((en_w & seen) != 3'b000) extra++;
        if (first < 0) begin first = c; first_bits = en_w; end
        seen |= en_w; last = c; done_at = c + dly;
      end
      if (sched_phase == 2'd2) ph2 = 1'b1;
      move_done = (c == done_at);
      if (cycle_done) begin dones++; lat = c; break; end
    end
    move_done = 1'b0;
  endtask

  // Expected-value table. Latency = 2 + n*dly + (n-1)*(GAP+2) + 2 for n phases.
  typedef struct {
    logic [2:0] mask;
    int         dly;
    logic [2:0] exp_seen;
    int         exp_first;
    int         exp_last;
    int         exp_lat;
    bit         exp_ph2;
  } vec_t;
  vec_t vt[8];

  // ---------------- reference model (event times, absolute cycle numbers) --
  bit         m_busy, m_done, m_wait;
  int         m_phase, m_ovr, m_en_at, m_fin_at;
  logic [2:0] m_mask, m_en;

  function automatic int next_phase(input logic [2:0] m, input int after);
    for (int p = after + 1; p <= 3; p++) if (m[p-1]) return p;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_wait = 0; m_phase = 0; m_ovr = 0;
    m_en_at = -1; m_fin_at = -1; m_mask = 3'b000; m_en = 3'b000;
  endtask

  // Given inputs during cycle t, produce expected outputs for cycle t+1.
  task automatic model_step(input bit tick, input logic [2:0] mask, input bit ok,
                            input bit md, input bit clr, input int t);
    int n_phase = m_phase, n_ovr = m_ovr, nx;
    bit n_busy = m_busy, n_done = 1'b0;
    logic [2:0] n_en = 3'b000;
    if (clr) n_ovr = 0;
    else if (tick && (m_busy || !ok)) n_ovr = (m_ovr == 255) ? 255 : m_ovr + 1;
    if (m_busy && !ok) begin
      n_busy = 0; n_phase = 0; m_en_at = -1; m_fin_at = -1; m_wait = 0;
    end else if (!m_busy) begin
      if (tick && ok) begin
        m_mask = mask; n_busy = 1; m_wait = 0;
        n_phase = next_phase(mask, 0);
        if (n_phase == 0) m_fin_at = t + 2; else m_en_at = t + 2;
      end
    end else begin
      if (m_wait && md) begin
        m_wait = 0;
        nx = next_phase(m_mask, m_phase);
        if (nx != 0) begin n_phase = nx; m_en_at = t + GAP + 2; end
        else m_fin_at = t + 2;
      end
      if (m_en_at == t + 1) begin n_en[m_phase-1] = 1'b1; m_wait = 1; m_en_at = -1; end
      if (m_fin_at == t + 1) begin n_done = 1; n_busy = 0; n_phase = 0; m_fin_at = -1; end
    end
    m_busy = n_busy; m_phase = n_phase; m_en = n_en; m_done = n_done; m_ovr = n_ovr;
  endtask

  initial begin
    logic [2:0] seen, fb;
    int first, last, lat, dones, extra, cnt, rel, err_at, done_at;
    bit ph2, ok_r, tk, md, clr;
    logic [2:0] mk;

    vt[0] = '{3'b000,  4, 3'b000, -1, -1,  2, 1'b0};
    vt[1] = '{3'b001, 10, 3'b001,  2,  2, 14, 1'b0};
    vt[2] = '{3'b010,  3, 3'b010,  2,  2,  7, 1'b1};
    vt[3] = '{3'b100,  0, 3'b100,  2,  2,  4, 1'b0};
    vt[4] = '{3'b101,  5, 3'b101,  2, 11, 18, 1'b0};
    vt[5] = '{3'b111, 10, 3'b111,  2, 30, 42, 1'b1};
    vt[6] = '{3'b011,  1, 3'b011,  2,  7, 10, 1'b1};
    vt[7] = '{3'b110,  7, 3'b110,  2, 13, 22, 1'b1};

    sys_rst = 1'b1; init_ok = 1'b1; cycle_tick = 1'b0; move_done = 1'b0;
    err_clr = 1'b0; phase_mask = 3'b000;

    // ---- reset state
    repeat (3) step();
    check("rst_en", en_w, 0);
    check("rst_busy", sched_busy, 0);
    check("rst_phase", sched_phase, 0);
    check("rst_done", cycle_done, 0);
    check("rst_ovr", ovr_cnt, 0);
    check("rst_err", sched_err, 0);
    sys_rst = 1'b0;
    step();
    check("post_rst_busy", sched_busy, 0);

    // ---- table-driven single cycles
    foreach (vt[i]) begin
      run_vec(vt[i].mask, vt[i].dly, seen, fb, first, last, lat, ph2, dones, extra);
      check($sformatf("v%0d_busy_after", i), sched_busy, 0);
      check($sformatf("v%0d_phase_after", i), sched_phase, 0);
      repeat (3) begin
        step();
        if (en_w != 3'b000 || cycle_done) extra++;
      end
      check($sformatf("v%0d_en_seen", i), seen, vt[i].exp_seen);
      check($sformatf("v%0d_first_en", i), first, vt[i].exp_first);
      check($sformatf("v%0d_last_en", i), last, vt[i].exp_last);
      check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_phase2_seen", i), ph2, vt[i].exp_ph2);
      check($sformatf("v%0d_dones", i), dones, 1);
      check($sformatf("v%0d_extra_pulses", i), extra, 0);
      check($sformatf("v%0d_ovr", i), ovr_cnt, 0);
    end

    // ---- overrun: ticks during WAIT and while unconfigured
    phase_mask = 3'b001; cycle_tick = 1'b1;
    step();
    cycle_tick = 1'b0;
    wait_en(0, "ovr_in_en");
    repeat (3) step();
    cycle_tick = 1'b1;
    step();
    cycle_tick = 1'b0;
    check("ovr_one", ovr_cnt, 1);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cycle_tick = 1'b1; step(); if (en_w != 3'b000) cnt++;
      cycle_tick = 1'b0; step(); if (en_w != 3'b000) cnt++;
    end
    check("ovr_saturated", ovr_cnt, 8'hFF);
    check("ovr_no_extra_en", cnt, 0);
    err_clr = 1'b1; cycle_tick = 1'b1;
    step();
    err_clr = 1'b0; cycle_tick = 1'b0;
    check("ovr_clr_wins", ovr_cnt, 0);
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10 && cnt == 0; i++) begin if (cycle_done) cnt++; else step(); end
    check("ovr_cycle_done", cnt, 1);
    step();
    init_ok = 1'b0; cycle_tick = 1'b1;
    step();
    init_ok = 1'b1; cycle_tick = 1'b0;
    check("ovr_unconfigured", ovr_cnt, 1);
    step();
    check("ovr_unconfigured_not_accepted", sched_busy, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // ---- init_ok dropped during the xnet WAIT
    phase_mask = 3'b111; cycle_tick = 1'b1;
    step();
    cycle_tick = 1'b0;
    wait_en(0, "abort_in_en");
    move_done = 1'b1; step(); move_done = 1'b0;
    wait_en(1, "abort_xnet_en");
    repeat (3) step();
    init_ok = 1'b0;
    step();
    check("abort_busy", sched_busy, 0);
    check("abort_phase", sched_phase, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) init_ok = 1'b1;
      move_done = (i == 5);
      step();
      if (xfer_out_en || cycle_done) cnt++;
    end
    move_done = 1'b0;
    check("abort_no_out_or_done", cnt, 0);

    // ---- reset mid-WAIT, then a fresh cycle
    phase_mask = 3'b111; cycle_tick = 1'b1;
    step();
    cycle_tick = 1'b0;
    wait_en(0, "rstmid_in_en");
    repeat (3) step();
    sys_rst = 1'b1;
    #2;
    check("rstmid_en", en_w, 0);
    check("rstmid_busy", sched_busy, 0);
    check("rstmid_phase", sched_phase, 0);
    check("rstmid_ovr_err_done", {ovr_cnt, sched_err, cycle_done}, 0);
    step();
    sys_rst = 1'b0;
    step();
    run_vec(3'b111, 4, seen, fb, first, last, lat, ph2, dones, extra);
    check("rstmid_first_is_in", fb, 3'b001);
    check("rstmid_first_cycle", first, 2);
    check("rstmid_dones", dones, 1);

`ifdef XFER_SCHED_WDT_EN
    // ---- watchdog timeout, no move_done
    step();
    phase_mask = 3'b011; cycle_tick = 1'b1;
    step();
    cycle_tick = 1'b0;
    wait_en(0, "wdt_in_en");
    err_at = -1; cnt = 0; dones = 0;
    for (int r = 1; r <= 300; r++) begin
      step();
      if (sched_err && err_at < 0) err_at = r;
      if (xnet_en) cnt++;
      if (cycle_done) dones++;
    end
    check("wdt_err_near_100", (err_at >= 95 && err_at <= 105), 1);
    check("wdt_no_xnet", cnt, 0);
    check("wdt_cycle_done", dones, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("wdt_err_clr", sched_err, 0);
    // move_done in the very clock the counter reaches the limit
    phase_mask = 3'b001; cycle_tick = 1'b1;
    step();
    cycle_tick = 1'b0;
    wait_en(0, "wdt2_in_en");
    dones = 0;
    for (rel = 1; rel <= 110; rel++) begin
      step();
      move_done = (rel == 100);
      if (cycle_done) dones++;
    end
    move_done = 1'b0;
    check("wdt_done_wins_err", sched_err, 0);
    check("wdt_done_wins_cycle_done", dones, 1);
`endif

    // ---- random stimulus against the reference model
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    cycle_tick = 1'b0; move_done = 1'b0; err_clr = 1'b0; init_ok = 1'b1;
    model_reset();
    ok_r = 1'b1; done_at = -1;
    for (int t = 0; t < 4000; t++) begin
      step();
      check($sformatf("rand_t%0d {en,busy,phase,done,ovr,err}", t),
            {en_w, sched_busy, sched_phase, cycle_done, ovr_cnt, sched_err},
            {m_en, m_busy, 2'(m_phase), m_done, 8'(m_ovr), 1'b0});
      if (ok_r) ok_r = ($urandom_range(0, 59) != 0);
      else      ok_r = ($urandom_range(0, 3) == 0);
      tk  = ($urandom_range(0, 7) == 0);
      mk  = 3'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      if (m_en != 3'b000) done_at = t + $urandom_range(0, 12);
      md  = (t == done_at) || ($urandom_range(0, 29) == 0);
      init_ok = ok_r; cycle_tick = tk; phase_mask = mk; move_done = md; err_clr = clr;
      model_step(tk, mk, ok_r, md, clr, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
